// File: rtl/trghist_reader_pkg.sv
// Shared definitions for the trigger-history reader: block word layout,
// FSM state encoding and word-building helpers.
// Optional feature macro: TRGHIST_MISSCNT_EN (adds the dropped-trigger word W2).
package trghist_reader_pkg;

  localparam int HDR_FLAG    = 15;  // bit set only in the block header word W0
  localparam int LEN_BITS    = 12;  // length field of W0
  localparam int SAMPLE_BITS = 15;  // history sample / payload field width
  localparam int WORD_BITS   = 16;  // output FIFO word width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_TNUM  = 3'd2,
    ST_MISS  = 3'd3,
    ST_READ  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  // Header word: flag, three zero bits, count of words following the header.
  function automatic logic [WORD_BITS-1:0] mk_hdr(input logic [LEN_BITS-1:0] len);
    return {1'b1, 3'b000, len};
  endfunction

  // Payload word: flag clear, 15-bit value.
  function automatic logic [WORD_BITS-1:0] mk_data(input logic [SAMPLE_BITS-1:0] val);
    return {1'b0, val};
  endfunction

endpackage

// File: rtl/trghist_reader_chk.sv
// Assertion checker for the reader: the FIFO must never be written while full,
// since space for a whole block is reserved when its trigger is accepted.
module trghist_reader_chk (
  input logic clk,
  input logic reset,
  input logic wr_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_i && full_i));

endmodule

// File: rtl/trghist_reader_hist_fifo.sv
// hist_fifo: first-word-fall-through FIFO, 2**FBITS x 16. The head word is
// held in a register loaded from the RAM at the next read pointer, with a
// bypass of the incoming word when it becomes the head. When the FIFO goes
// empty the head register keeps the last word that was popped.
module hist_fifo #(
  parameter int FBITS = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [15:0]      wdata_i,
  input  logic             rd_i,
  output logic [15:0]      dout_o,
  output logic             pop_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [FBITS:0]   free_o
);

  localparam int DEPTH = 2 ** FBITS;
  localparam int CW    = FBITS + 1;

  logic [15:0]      mem_q [DEPTH];
  logic [FBITS-1:0] wptr_q, wptr_d;
  logic [FBITS-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      dout_q, dout_d;
  logic             pop_s;

  // Pointer/count next state and head-word selection.
  always_comb begin
    pop_s  = rd_i && (cnt_q != {CW{1'b0}});
    wptr_d = wptr_q + {{(FBITS-1){1'b0}}, wr_i};
    rptr_d = rptr_q + {{(FBITS-1){1'b0}}, pop_s};
    cnt_d  = cnt_q + {{FBITS{1'b0}}, wr_i} - {{FBITS{1'b0}}, pop_s};
    dout_d = dout_q;
    if (cnt_d == {CW{1'b0}}) begin
      dout_d = dout_q;
    end else if (cnt_q == {{FBITS{1'b0}}, pop_s}) begin
      dout_d = wdata_i;
    end else begin
      dout_d = mem_q[rptr_d];
    end
  end

  // Storage array; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= {FBITS{1'b0}};
      rptr_q <= {FBITS{1'b0}};
      cnt_q  <= {CW{1'b0}};
      dout_q <= 16'h0000;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign pop_o   = pop_s;
  assign empty_o = (cnt_q == {CW{1'b0}});
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign free_o  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/trghist_reader.sv
// trghist_reader: on each accepted trigger reads a window of history samples
// around the trigger point and queues it as one block in the output FIFO:
//   W0 = {1, 000, len}, W1 = {0, trgnum}, [W2 = {0, misscnt}], samples...
// Optional feature macro: TRGHIST_MISSCNT_EN (saturating dropped-trigger
// counter reported as W2; cleared when W2 is written).
module trghist_reader
  import trghist_reader_pkg::*;
#(
  parameter int CBITS = 10,
  parameter int FBITS = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CBITS-1:0] tr_addr,
  input  logic [CBITS-1:0] cb_waddr,
  output logic [CBITS-1:0] cb_raddr,
  input  logic [14:0]      cb_data,
  input  logic [CBITS-1:0] winbeg,
  input  logic [8:0]       winlen,
  input  logic             give,
  output logic             have,
  output logic [15:0]      dout
);

`ifdef TRGHIST_MISSCNT_EN
  localparam int HDR_WORDS = 2;
`else
  localparam int HDR_WORDS = 1;
`endif
  localparam int FW = FBITS + 1;

  state_e           state_q, state_d;
  logic [CBITS-1:0] raddr_q, raddr_d;
  logic [8:0]       rem_q, rem_d;
  logic [8:0]       wlen_q, wlen_d;
  logic [14:0]      tnum_q, tnum_d;
  logic [14:0]      tsnap_q, tsnap_d;
  logic             rdpend_q, rdpend_d;
  logic [FW-1:0]    blk_q, blk_d;
  logic             have_q, have_d;

  logic             accept_s, drop_s, blk_inc_s, blk_dec_s;
  logic             fwr_s, fpop_s, fempty_s, ffull_s;
  logic [15:0]      fwdata_s, fdout_s;
  logic [FW-1:0]    ffree_s, need_s;
  logic [LEN_BITS-1:0] len_s;

`ifdef TRGHIST_MISSCNT_EN
  logic [15:0] miss_q, miss_d;
  logic [14:0] miss_word_s;
  logic        miss_clr_s;
`endif

  // Header length of the current block and FIFO words needed by a new one.
  always_comb begin
    len_s  = LEN_BITS'(wlen_q) + LEN_BITS'(HDR_WORDS);
    need_s = FW'(winlen) + FW'(HDR_WORDS + 1);
  end

  // Block FSM: accept/drop triggers, emit header words, issue reads.
  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    rem_d     = rem_q;
    wlen_d    = wlen_q;
    tsnap_d   = tsnap_q;
    rdpend_d  = 1'b0;
    accept_s  = 1'b0;
    blk_inc_s = 1'b0;
    fwr_s     = 1'b0;
    fwdata_s  = 16'h0000;
`ifdef TRGHIST_MISSCNT_EN
    miss_clr_s = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trig && (winlen != 9'd0) && (ffree_s >= need_s)) begin
          accept_s = 1'b1;
          raddr_d  = tr_addr - winbeg;
          rem_d    = winlen;
          wlen_d   = winlen;
          tsnap_d  = tnum_q;
          state_d  = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        fwr_s    = 1'b1;
        fwdata_s = mk_hdr(len_s);
        state_d  = ST_TNUM;
      end
      ST_TNUM: begin
        fwr_s    = 1'b1;
        fwdata_s = mk_data(tsnap_q);
`ifdef TRGHIST_MISSCNT_EN
        state_d  = ST_MISS;
`else
        state_d  = ST_READ;
`endif
      end
`ifdef TRGHIST_MISSCNT_EN
      ST_MISS: begin
        fwr_s      = 1'b1;
        fwdata_s   = mk_data(miss_word_s);
        miss_clr_s = 1'b1;
        state_d    = ST_READ;
      end
`endif
      ST_READ: begin
        // Data for the address issued last cycle arrives now.
        if (rdpend_q) begin
          fwr_s    = 1'b1;
          fwdata_s = mk_data(cb_data);
        end else begin
          fwr_s = 1'b0;
        end
        // The slot at the write address has not been filled yet: wait.
        if (raddr_q != cb_waddr) begin
          rdpend_d = 1'b1;
          raddr_d  = raddr_q + {{(CBITS-1){1'b0}}, 1'b1};
          rem_d    = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          rdpend_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        fwr_s     = 1'b1;
        fwdata_s  = mk_data(cb_data);
        blk_inc_s = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Trigger numbering and count of complete blocks waiting in the FIFO.
  always_comb begin
    drop_s    = trig && !accept_s;
    tnum_d    = trig ? (tnum_q + 15'd1) : tnum_q;
    blk_dec_s = fpop_s && fdout_s[HDR_FLAG];
    blk_d     = blk_q + {{FBITS{1'b0}}, blk_inc_s} - {{FBITS{1'b0}}, blk_dec_s};
    have_d    = (blk_d != {FW{1'b0}});
  end

`ifdef TRGHIST_MISSCNT_EN
  // Saturating dropped-trigger counter; restarts when reported in W2.
  always_comb begin
    miss_word_s = (miss_q > 16'h7FFF) ? 15'h7FFF : miss_q[14:0];
    if (miss_clr_s) begin
      miss_d = drop_s ? 16'h0001 : 16'h0000;
    end else if (drop_s && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'h0001;
    end else begin
      miss_d = miss_q;
    end
  end

  // Dropped-trigger counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q <= 16'h0000;
    end else begin
      miss_q <= miss_d;
    end
  end
`endif

  // State, address/length counters, trigger number and block count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      raddr_q  <= {CBITS{1'b0}};
      rem_q    <= 9'd0;
      wlen_q   <= 9'd0;
      tnum_q   <= 15'd0;
      tsnap_q  <= 15'd0;
      rdpend_q <= 1'b0;
      blk_q    <= {FW{1'b0}};
      have_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      rem_q    <= rem_d;
      wlen_q   <= wlen_d;
      tnum_q   <= tnum_d;
      tsnap_q  <= tsnap_d;
      rdpend_q <= rdpend_d;
      blk_q    <= blk_d;
      have_q   <= have_d;
    end
  end

  hist_fifo #(.FBITS(FBITS)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (fwr_s),
    .wdata_i (fwdata_s),
    .rd_i    (give),
    .dout_o  (fdout_s),
    .pop_o   (fpop_s),
    .empty_o (fempty_s),
    .full_o  (ffull_s),
    .free_o  (ffree_s)
  );

  trghist_reader_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (fwr_s),
    .full_i (ffull_s || (fempty_s && 1'b0))
  );

  assign cb_raddr = raddr_q;
  assign have     = have_q;
  assign dout     = fdout_s;

endmodule

// File: tb/tb_trghist_reader.sv
// Directed bench for trghist_reader: a 1024-word history buffer model with
// one-clock read latency, preloaded so that every address holds its own value.
module tb_trghist_reader;

`ifdef TRGHIST_MISSCNT_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 1;
`endif

  logic        clk;
  logic        reset;
  logic        trig;
  logic [9:0]  tr_addr;
  logic [9:0]  cb_waddr;
  logic [9:0]  cb_raddr;
  logic [14:0] cb_data;
  logic [9:0]  winbeg;
  logic [8:0]  winlen;
  logic        give;
  logic        have;
  logic [15:0] dout;

  logic [14:0] cbuf [1024];
  logic [15:0] exp_q [$];
  int          n_chk;
  int          n_pass;
`ifdef TRGHIST_MISSCNT_EN
  logic [14:0] exp_miss;
`endif

  trghist_reader #(.CBITS(10), .FBITS(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .trig     (trig),
    .tr_addr  (tr_addr),
    .cb_waddr (cb_waddr),
    .cb_raddr (cb_raddr),
    .cb_data  (cb_data),
    .winbeg   (winbeg),
    .winlen   (winlen),
    .give     (give),
    .have     (have),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // History buffer read port: data valid one clock after the address.
  always @(posedge clk) cb_data <= cbuf[cb_raddr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic trig_at(input logic [9:0] a);
    tr_addr = a;
    trig    = 1'b1;
    @(posedge clk); #1;
    trig    = 1'b0;
  endtask

  task automatic note_drop();
`ifdef TRGHIST_MISSCNT_EN
    exp_miss = exp_miss + 15'd1;
`endif
  endtask

  // Append the expected words of one accepted block.
  task automatic make_exp(input logic [9:0] start, input int wl, input logic [14:0] tn);
    logic [9:0] a;
    exp_q.push_back({1'b1, 3'b000, 12'(wl + EXTRA)});
    exp_q.push_back({1'b0, tn});
`ifdef TRGHIST_MISSCNT_EN
    exp_q.push_back({1'b0, exp_miss});
    exp_miss = 15'd0;
`endif
    for (int i = 0; i < wl; i++) begin
      a = start + 10'(i);
      exp_q.push_back({6'b000000, a});
    end
  endtask

  task automatic wait_have(input string tag, input int budget);
    int n;
    n = 0;
    while (!have && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_have"}, {31'd0, have}, 32'd1);
  endtask

  // Pop one block with give held high, checking each head word.
  task automatic read_block(input string tag, input int wl);
    give = 1'b1;
    for (int i = 0; i < wl + 1 + EXTRA; i++) begin
      chk($sformatf("%s[%0d]", tag, i), {16'd0, dout}, {16'd0, exp_q.pop_front()});
      @(posedge clk); #1;
    end
    give = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    reset    = 1'b1;
    trig     = 1'b0;
    tr_addr  = 10'h000;
    cb_waddr = 10'h200;
    winbeg   = 10'h000;
    winlen   = 9'd0;
    give     = 1'b0;
`ifdef TRGHIST_MISSCNT_EN
    exp_miss = 15'd0;
`endif
    for (int i = 0; i < 1024; i++) cbuf[i] = 15'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_have", {31'd0, have}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_raddr", {22'd0, cb_raddr}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic window 0x0F8..0x107, trgnum 0
    winbeg = 10'd8;
    winlen = 9'd16;
    trig_at(10'h100);
    make_exp(10'h0F8, 16, 15'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("a_have_early", {31'd0, have}, 32'd0);
    wait_have("a", 200);
    read_block("a", 16);
    chk("a_have_after", {31'd0, have}, 32'd0);

    // Window wrapping below address 0, trgnum 1
    winlen = 9'd4;
    trig_at(10'h005);
    make_exp(10'h3FD, 4, 15'd1);
    wait_have("w", 200);
    read_block("w", 4);

    // winlen 0: trigger dropped, trgnum 2 consumed
    winlen = 9'd0;
    trig_at(10'h100);
    note_drop();
    repeat (20) @(posedge clk);
    #1;
    chk("dis_have", {31'd0, have}, 32'd0);

    // Stall at the write address, trgnum 3
    winbeg   = 10'd2;
    winlen   = 9'd6;
    cb_waddr = 10'h052;
    cbuf[10'h052] = 15'h7777;
    cbuf[10'h053] = 15'h6666;
    trig_at(10'h050);
    make_exp(10'h04E, 6, 15'd3);
    repeat (20) @(posedge clk);
    #1;
    chk("st_have", {31'd0, have}, 32'd0);
    chk("st_raddr", {22'd0, cb_raddr}, 32'h052);
    cbuf[10'h052] = 15'h0052;
    cbuf[10'h053] = 15'h0053;
    cb_waddr = 10'h060;
    wait_have("st", 200);
    read_block("st", 6);

    // Second trigger three clocks after an accepted one is dropped
    winbeg   = 10'd8;
    winlen   = 9'd16;
    cb_waddr = 10'h200;
    trig_at(10'h100);
    make_exp(10'h0F8, 16, 15'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    trig_at(10'h180);
    note_drop();
    wait_have("d1", 200);
    read_block("d1", 16);
    trig_at(10'h120);
    make_exp(10'h118, 16, 15'd6);
    wait_have("d2", 200);
    read_block("d2", 16);

    // Three full-size blocks fill the FIFO; the fourth trigger is dropped
    winbeg   = 10'd0;
    winlen   = 9'd511;
    cb_waddr = 10'h3FF;
    for (int b = 0; b < 3; b++) begin
      trig_at(10'h200);
      make_exp(10'h200, 511, 15'(7 + b));
      repeat (600) @(posedge clk);
      #1;
    end
    trig_at(10'h200);
    note_drop();
    repeat (600) @(posedge clk);
    #1;
    chk("f_have", {31'd0, have}, 32'd1);
    for (int b = 0; b < 3; b++) begin
      read_block($sformatf("f%0d", b), 511);
      chk($sformatf("f%0d_have_after", b), {31'd0, have}, (b < 2) ? 32'd1 : 32'd0);
    end
    give = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    give = 1'b0;
    chk("f_empty_dout", {16'd0, dout}, 32'h03FE);
    chk("f_empty_have", {31'd0, have}, 32'd0);

    // Reset in the middle of a block
    winbeg = 10'd8;
    winlen = 9'd16;
    trig_at(10'h100);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_have", {31'd0, have}, 32'd0);
    chk("mr_dout", {16'd0, dout}, 32'd0);
    chk("mr_raddr", {22'd0, cb_raddr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef TRGHIST_MISSCNT_EN
    exp_miss = 15'd0;
`endif
    @(posedge clk); #1;
    trig_at(10'h100);
    make_exp(10'h0F8, 16, 15'd0);
    wait_have("mr", 200);
    read_block("mr", 16);
    chk("mr_have_after", {31'd0, have}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
